multi_road_signal: RTL

MULTI_ROAD_SIGNAL -- requirements
Module: multi_road_signal

---
 rtl/traffic_pkg.sv | 16 +
 rtl/signal_rr_pick.sv | 27 ++
 rtl/multi_road_signal.sv | 137 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared light encoding and phase enum for the multi-road signal controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_GREEN  = 2'b10
    } light_e;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10
    } phase_e;

endpackage

// File: rtl/signal_rr_pick.sv
// Round-robin search over side roads 1..N_ROADS-1, starting after last_side.
module signal_rr_pick #(
    parameter  int N_ROADS = 4,
    localparam int AW      = $clog2(N_ROADS)
) (
    input  logic [N_ROADS-1:1] req,
    input  logic [AW-1:0]      last_side,
    output logic [AW-1:0]      grant,
    output logic               valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 1; i < N_ROADS; i++) begin
            idx = ((int'(last_side) - 1 + i) % (N_ROADS - 1)) + 1;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = AW'(idx);
            end
        end
    end

endmodule

// File: rtl/multi_road_signal.sv
// Traffic controller: road 0 is the major road, side roads are served
// round-robin on demand with yellow and all-red clearance between greens.
module multi_road_signal
    import traffic_pkg::*;
#(
    parameter  int N_ROADS   = 4,
    parameter  int GREEN_MIN = 8,
    parameter  int GREEN_MAX = 20,
    parameter  int YELLOW_T  = 3,
    parameter  int ALLRED_T  = 2,
    localparam int AW        = $clog2(N_ROADS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_ROADS-1:0]   sensor,
    output logic [2*N_ROADS-1:0] sig,
    output logic [AW-1:0]        active,
    output logic [1:0]           phase
);

    localparam int T_GY  = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int T_MAX = (T_GY > ALLRED_T) ? T_GY : ALLRED_T;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] GMIN1   = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX1   = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL1    = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AR1     = CW'(ALLRED_T - 1);
    localparam logic [AW-1:0] LAST_RST = AW'(N_ROADS - 1);

    if (N_ROADS < 2 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN ||
        YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_params
        $error("multi_road_signal: illegal parameter combination");
    end

    phase_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        active_q, active_d;
    logic [AW-1:0]        last_side_q, last_side_d;
    logic [N_ROADS-1:0]   sensor_q;
    logic                 boot_q, boot_d;

    logic [AW-1:0]        pick;
    logic                 pick_valid;
    logic                 side_dem;
    logic                 go;

    signal_rr_pick #(.N_ROADS(N_ROADS)) u_pick (
        .req       (sensor_q[N_ROADS-1:1]),
        .last_side (last_side_q),
        .grant     (pick),
        .valid     (pick_valid)
    );

    assign side_dem = |sensor_q[N_ROADS-1:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PH_ALL_RED;
            cnt_q       <= '0;
            active_q    <= '0;
            last_side_q <= LAST_RST;
            sensor_q    <= '0;
            boot_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            last_side_q <= last_side_d;
            sensor_q    <= sensor;
            boot_q      <= boot_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        active_d    = active_q;
        last_side_d = last_side_q;
        boot_d      = boot_q;
        go          = 1'b0;
        unique case (state_q)
            PH_GREEN: begin
                if (active_q == '0)
                    go = (cnt_q >= GMIN1) && side_dem;
                else
                    go = ((cnt_q >= GMIN1) && !sensor_q[active_q]) ||
                         (cnt_q == GMAX1);
                if (go) begin
                    state_d = PH_YELLOW;
                    cnt_d   = '0;
                end
            end
            PH_YELLOW: begin
                if (cnt_q == YEL1) begin
                    state_d = PH_ALL_RED;
                    cnt_d   = '0;
                end
            end
            PH_ALL_RED: begin
                if (cnt_q == AR1) begin
                    state_d = PH_GREEN;
                    cnt_d   = '0;
                    boot_d  = 1'b0;
                    // Side demand is re-sampled here so vanished demand falls back to road 0.
                    if (active_q == '0 && !boot_q && pick_valid) begin
                        active_d    = pick;
                        last_side_d = pick;
                    end else begin
                        active_d = '0;
                    end
                end
            end
            default: begin
                state_d = PH_ALL_RED;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sig = '0;
        for (int k = 0; k < N_ROADS; k++) begin
            if (AW'(k) == active_q) begin
                if (state_q == PH_GREEN)
                    sig[2*k +: 2] = LIGHT_GREEN;
                else if (state_q == PH_YELLOW)
                    sig[2*k +: 2] = LIGHT_YELLOW;
            end
        end
    end

    assign active = active_q;
    assign phase  = state_q;

endmodule
